// File: rtl/rf_wb_pkg.sv
// Shared types and default widths for the register-file writeback arbiter.
package rf_wb_pkg;

  localparam int unsigned ADDR_W_DEF = 4;
  localparam int unsigned DATA_W_DEF = 8;
  localparam int unsigned CNT_W_DEF  = 2;

  typedef struct packed {
    logic                  valid;
    logic [ADDR_W_DEF-1:0] addr;
    logic [DATA_W_DEF-1:0] data;
  } wb_req_t;

  typedef enum logic {
    REQ_ALU = 1'b0,
    REQ_MEM = 1'b1
  } requester_e;

endpackage

// File: rtl/rf_wb_arbiter_if.sv
// Writeback requester handshakes and the register-file write port.
interface rf_wb_arbiter_if
  import rf_wb_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF
);

  logic              alu_valid_i;
  logic              alu_ready_o;
  logic [ADDR_W-1:0] alu_addr_i;
  logic [DATA_W-1:0] alu_data_i;

  logic              mem_valid_i;
  logic              mem_ready_o;
  logic [ADDR_W-1:0] mem_addr_i;
  logic [DATA_W-1:0] mem_data_i;

  logic              we3_o;
  logic [ADDR_W-1:0] wa3_o;
  logic [DATA_W-1:0] wd3_o;

  // Arbiter side
  modport slave (
    input  alu_valid_i, alu_addr_i, alu_data_i,
    input  mem_valid_i, mem_addr_i, mem_data_i,
    output alu_ready_o, mem_ready_o,
    output we3_o, wa3_o, wd3_o
  );

  // Requester / register-file side
  modport master (
    output alu_valid_i, alu_addr_i, alu_data_i,
    output mem_valid_i, mem_addr_i, mem_data_i,
    input  alu_ready_o, mem_ready_o,
    input  we3_o, wa3_o, wd3_o
  );

endinterface

// File: rtl/rr_arb2.sv
// Two-input round-robin arbiter; the last-grant pointer moves only on a transfer.
module rr_arb2
  import rf_wb_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] gnt
);

  requester_e last_q;

  // Grant is a pure function of valids and pointer, never of payload
  always_comb begin
    gnt = 2'b00;
    unique case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = (last_q == REQ_MEM) ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      last_q <= REQ_MEM;
    end else if (advance) begin
      last_q <= gnt[1] ? REQ_MEM : REQ_ALU;
    end
  end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Shares the register-file write port between ALU and memory writeback and
// tracks pending writes per register to raise RAW stalls at decode.
module rf_wb_arbiter
  import rf_wb_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned CNT_W  = CNT_W_DEF
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  rf_wb_arbiter_if.slave         bus,
  input  logic                   rsv_valid_i,
  input  logic [ADDR_W-1:0]      rsv_addr_i,
  output logic                   rsv_ready_o,
  input  logic [ADDR_W-1:0]      ra1_i,
  input  logic [ADDR_W-1:0]      ra2_i,
  input  logic                   ra1_use_i,
  input  logic                   ra2_use_i,
  output logic                   stall_o,
  output logic [(2**ADDR_W)-1:0] busy_o,
  output logic                   err_o
);

  localparam int unsigned NREG = 2 ** ADDR_W;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  wb_req_t alu_req;
  wb_req_t mem_req;
  wb_req_t sel_req;
  logic [1:0] gnt;
  logic       xfer;

  logic              we3_q;
  logic [ADDR_W-1:0] wa3_q;
  logic [DATA_W-1:0] wd3_q;
  logic              err_q;

  logic [CNT_W-1:0] cnt_q [NREG];
  logic [CNT_W-1:0] cnt_d [NREG];
  logic             rsv_fire;

  always_comb begin
    alu_req = '{valid: bus.alu_valid_i,
                addr:  ADDR_W_DEF'(bus.alu_addr_i),
                data:  DATA_W_DEF'(bus.alu_data_i)};
    mem_req = '{valid: bus.mem_valid_i,
                addr:  ADDR_W_DEF'(bus.mem_addr_i),
                data:  DATA_W_DEF'(bus.mem_data_i)};
  end

  rr_arb2 u_arb (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .req     ({bus.mem_valid_i, bus.alu_valid_i}),
    .advance (xfer),
    .gnt     (gnt)
  );

  assign sel_req         = gnt[REQ_MEM] ? mem_req : alu_req;
  assign xfer            = (|gnt) && sel_req.valid;
  assign bus.alu_ready_o = gnt[REQ_ALU];
  assign bus.mem_ready_o = gnt[REQ_MEM];

  // Accepted request lands on the write port one cycle later
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      we3_q <= 1'b0;
      wa3_q <= '0;
      wd3_q <= '0;
    end else begin
      we3_q <= xfer;
      if (xfer) begin
        wa3_q <= ADDR_W'(sel_req.addr);
        wd3_q <= DATA_W'(sel_req.data);
      end
    end
  end

  assign bus.we3_o = we3_q;
  assign bus.wa3_o = wa3_q;
  assign bus.wd3_o = wd3_q;

  // A commit frees a slot in the same cycle, so a full counter can still reserve
  assign rsv_ready_o = (cnt_q[rsv_addr_i] != CNT_MAX) ||
                       (we3_q && (wa3_q == rsv_addr_i));
  assign rsv_fire    = rsv_valid_i && rsv_ready_o;

  always_comb begin
    for (int i = 0; i < NREG; i++) begin
      logic inc;
      logic dec;
      cnt_d[i] = cnt_q[i];
      inc      = rsv_fire && (rsv_addr_i == ADDR_W'(i));
      dec      = we3_q && (wa3_q == ADDR_W'(i));
      if (inc && dec) begin
        cnt_d[i] = cnt_q[i];
      end else if (inc) begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end else if (dec && (cnt_q[i] != '0)) begin
        cnt_d[i] = cnt_q[i] - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < NREG; i++) cnt_q[i] <= '0;
      err_q <= 1'b0;
    end else begin
      for (int i = 0; i < NREG; i++) cnt_q[i] <= cnt_d[i];
      err_q <= we3_q && (cnt_q[wa3_q] == '0);
    end
  end

  assign err_o = err_q;

  always_comb begin
    busy_o = '0;
    for (int i = 0; i < NREG; i++) busy_o[i] = (cnt_q[i] != '0);
  end

  // No bypass: stall clears only once the counter itself has dropped
  assign stall_o = (ra1_use_i && busy_o[ra1_i]) || (ra2_use_i && busy_o[ra2_i]);

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed bench for rf_wb_arbiter: arbitration, write latency, scoreboard and reset.
module tb_rf_wb_arbiter;
  import rf_wb_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        rsv_valid;
  logic [3:0]  rsv_addr;
  logic        rsv_ready;
  logic [3:0]  ra1, ra2;
  logic        ra1_use, ra2_use;
  logic        stall;
  logic [15:0] busy;
  logic        err;

  int checks = 0;
  int errors = 0;

  rf_wb_arbiter_if bus ();

  rf_wb_arbiter dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .bus         (bus),
    .rsv_valid_i (rsv_valid),
    .rsv_addr_i  (rsv_addr),
    .rsv_ready_o (rsv_ready),
    .ra1_i       (ra1),
    .ra2_i       (ra2),
    .ra1_use_i   (ra1_use),
    .ra2_use_i   (ra2_use),
    .stall_o     (stall),
    .busy_o      (busy),
    .err_o       (err)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic reserve(input logic [3:0] a);
    rsv_valid = 1'b1;
    rsv_addr  = a;
    #1;
    chk("rsv_ready", 32'(rsv_ready), 32'd1);
    tick();
    rsv_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    rsv_valid = 0; rsv_addr = 0;
    ra1 = 0; ra2 = 0; ra1_use = 1; ra2_use = 0;
    bus.alu_valid_i = 0; bus.alu_addr_i = 0; bus.alu_data_i = 0;
    bus.mem_valid_i = 0; bus.mem_addr_i = 0; bus.mem_data_i = 0;
    tick(); tick();
    rst = 1'b0;
    #1;
    chk("rst_we3", 32'(bus.we3_o), 32'd0);
    chk("rst_wa3", 32'(bus.wa3_o), 32'd0);
    chk("rst_wd3", 32'(bus.wd3_o), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_stall", 32'(stall), 32'd0);
    ra1_use = 0;

    // ALU-only write to R3
    reserve(4'd3);
    #1;
    chk("alu_busy3_pre", 32'(busy[3]), 32'd1);
    bus.alu_valid_i = 1; bus.alu_addr_i = 4'd3; bus.alu_data_i = 8'hA5;
    #1;
    chk("alu_ready", 32'(bus.alu_ready_o), 32'd1);
    chk("alu_mem_ready", 32'(bus.mem_ready_o), 32'd0);
    tick();
    bus.alu_valid_i = 0;
    chk("alu_we3", 32'(bus.we3_o), 32'd1);
    chk("alu_wa3", 32'(bus.wa3_o), 32'd3);
    chk("alu_wd3", 32'(bus.wd3_o), 32'hA5);
    chk("alu_busy3_commit", 32'(busy[3]), 32'd1);
    tick();
    chk("alu_busy3_post", 32'(busy[3]), 32'd0);
    chk("alu_we3_idle", 32'(bus.we3_o), 32'd0);
    chk("alu_wa3_hold", 32'(bus.wa3_o), 32'd3);
    chk("alu_err", 32'(err), 32'd0);

    // MEM write to unreserved R9
    bus.mem_valid_i = 1; bus.mem_addr_i = 4'd9; bus.mem_data_i = 8'h3C;
    #1;
    chk("unr_mem_ready", 32'(bus.mem_ready_o), 32'd1);
    tick();
    bus.mem_valid_i = 0;
    chk("unr_we3", 32'(bus.we3_o), 32'd1);
    chk("unr_wa3", 32'(bus.wa3_o), 32'd9);
    chk("unr_wd3", 32'(bus.wd3_o), 32'h3C);
    chk("unr_err_early", 32'(err), 32'd0);
    tick();
    chk("unr_err", 32'(err), 32'd1);
    chk("unr_busy9", 32'(busy[9]), 32'd0);
    tick();
    chk("unr_err_clear", 32'(err), 32'd0);

    // Contention: pointer is now last=MEM, so ALU leads
    reserve(4'd1); reserve(4'd2); reserve(4'd1); reserve(4'd2);
    #1;
    chk("cont_busy", 32'(busy), 32'h0006);
    bus.alu_valid_i = 1; bus.alu_addr_i = 4'd1; bus.alu_data_i = 8'h11;
    bus.mem_valid_i = 1; bus.mem_addr_i = 4'd2; bus.mem_data_i = 8'h22;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("cont_alu_ready", 32'(bus.alu_ready_o), (k % 2 == 0) ? 32'd1 : 32'd0);
      chk("cont_mem_ready", 32'(bus.mem_ready_o), (k % 2 == 0) ? 32'd0 : 32'd1);
      tick();
      if (k == 3) begin
        bus.alu_valid_i = 0; bus.mem_valid_i = 0;
      end
      chk("cont_we3", 32'(bus.we3_o), 32'd1);
      chk("cont_wa3", 32'(bus.wa3_o), (k % 2 == 0) ? 32'd1 : 32'd2);
      chk("cont_wd3", 32'(bus.wd3_o), (k % 2 == 0) ? 32'h11 : 32'h22);
    end
    tick();
    chk("cont_busy_done", 32'(busy), 32'd0);
    chk("cont_err", 32'(err), 32'd0);

    // RAW hazard on R5
    reserve(4'd5);
    ra1 = 4'd5; ra1_use = 1;
    #1;
    chk("haz_stall", 32'(stall), 32'd1);
    ra1_use = 0;
    #1;
    chk("haz_nouse", 32'(stall), 32'd0);
    ra1_use = 1; ra2 = 4'd5; ra2_use = 0;
    bus.alu_valid_i = 1; bus.alu_addr_i = 4'd5; bus.alu_data_i = 8'h55;
    tick();
    bus.alu_valid_i = 0;
    chk("haz_we3", 32'(bus.we3_o), 32'd1);
    chk("haz_wa3", 32'(bus.wa3_o), 32'd5);
    chk("haz_stall_inflight", 32'(stall), 32'd1);
    tick();
    chk("haz_stall_clear", 32'(stall), 32'd0);
    ra1_use = 0;

    // Saturation on R7
    reserve(4'd7); reserve(4'd7); reserve(4'd7);
    rsv_valid = 1; rsv_addr = 4'd7;
    #1;
    chk("sat_full", 32'(rsv_ready), 32'd0);
    rsv_valid = 0;
    bus.alu_valid_i = 1; bus.alu_addr_i = 4'd7; bus.alu_data_i = 8'h77;
    tick();
    bus.alu_valid_i = 0;
    rsv_valid = 1; rsv_addr = 4'd7;
    #1;
    chk("sat_commit_we3", 32'(bus.we3_o), 32'd1);
    chk("sat_commit_ready", 32'(rsv_ready), 32'd1);
    tick();
    #1;
    chk("sat_still_full", 32'(rsv_ready), 32'd0);
    rsv_valid = 0;
    bus.alu_valid_i = 1;
    tick(); tick(); tick();
    bus.alu_valid_i = 0;
    chk("sat_busy_one_left", 32'(busy[7]), 32'd1);
    tick();
    chk("sat_busy_drained", 32'(busy[7]), 32'd0);
    chk("sat_err", 32'(err), 32'd0);

    // Reset in the cycle of an ALU transfer; pointer currently last=ALU
    reserve(4'd4);
    bus.alu_valid_i = 1; bus.alu_addr_i = 4'd4; bus.alu_data_i = 8'h44;
    rst = 1;
    tick();
    rst = 0;
    bus.alu_valid_i = 0;
    chk("rstm_we3", 32'(bus.we3_o), 32'd0);
    chk("rstm_busy", 32'(busy), 32'd0);
    bus.alu_valid_i = 1; bus.alu_addr_i = 4'd6; bus.alu_data_i = 8'h66;
    bus.mem_valid_i = 1; bus.mem_addr_i = 4'd8; bus.mem_data_i = 8'h88;
    #1;
    chk("rstm_alu_wins", 32'(bus.alu_ready_o), 32'd1);
    chk("rstm_mem_waits", 32'(bus.mem_ready_o), 32'd0);
    tick();
    bus.alu_valid_i = 0; bus.mem_valid_i = 0;
    chk("rstm_wa3", 32'(bus.wa3_o), 32'd6);
    chk("rstm_wd3", 32'(bus.wd3_o), 32'h66);
    tick();
    chk("rstm_err_unreserved", 32'(err), 32'd1);
    tick();
    chk("rstm_err_clear", 32'(err), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rf_wb_arbiter.md
Name: rf_wb_arbiter

Overview:
- Shares the single register-file write port (we3/wa3/wd3) between two writeback requesters: the scalar ALU path and the memory/crypto-load path.
- Requesters use a valid/ready handshake. The port is granted round-robin, and the accepted write is registered onto the write port.
- Holds a per-register pending-write scoreboard. Decode reserves destinations at issue, and the block produces stall_o for read-after-write hazards on the two decode read addresses.

Parameters:
- ADDR_W, 4, register address width (2**ADDR_W registers)
- DATA_W, 8, register data width
- CNT_W, 2, per-register outstanding-write counter width (max 2**CNT_W-1 in flight per register)

Ports:
- clk_i  in  1  clock, rising edge
- rst_i  in  1  synchronous, active-high reset
- alu_valid_i  in  1  ALU writeback request
- alu_ready_o  out  1  ALU request granted this cycle
- alu_addr_i  in  ADDR_W  ALU destination register
- alu_data_i  in  DATA_W  ALU result
- mem_valid_i  in  1  memory-path writeback request
- mem_ready_o  out  1  memory request granted this cycle
- mem_addr_i  in  ADDR_W  memory destination register
- mem_data_i  in  DATA_W  memory result
- we3_o  out  1  register-file write enable
- wa3_o  out  ADDR_W  register-file write address
- wd3_o  out  DATA_W  register-file write data
- rsv_valid_i  in  1  decode reserves a destination register
- rsv_addr_i  in  ADDR_W  register being reserved
- rsv_ready_o  out  1  reservation accepted
- ra1_i, ra2_i  in  ADDR_W  decode source addresses
- ra1_use_i, ra2_use_i  in  1  source actually read
- stall_o  out  1  RAW hazard, decode must hold
- busy_o  out  2**ADDR_W  per-register "count != 0" vector
- err_o  out  1  one-cycle pulse on write to an unreserved register

Behaviour:

Reset:
- Synchronous, active-high.
- we3_o=0, wa3_o=0, wd3_o=0, err_o=0.
- All counters cleared, so busy_o=0 and stall_o=0.
- Round-robin pointer set to last=MEM, so ALU wins the first tie.
- Reset mid-operation discards any grant made in that cycle; no write appears afterwards.

Arbitration (combinational):
- Only one valid: that requester is granted.
- Both valid: the requester not granted last is granted.
- ready_o = grant. A transfer occurs when valid && ready.
- Pointer updates only on a transfer.
- Ready must not depend on data or address.
- A requester holds valid/addr/data stable until ready.

Write port:
- One-cycle latency: a transfer in cycle N gives we3_o=1 with that addr/data during cycle N+1.
- The register file captures at the end of N+1.
- With no transfer, we3_o=0 and wa3_o/wd3_o hold their last values.
- Sustained throughput is 1 write/cycle.

Scoreboard:
- One CNT_W counter per register.
- Increment on an accepted reservation (rsv_valid_i && rsv_ready_o).
- Decrement at the edge ending a cycle with we3_o=1, for cnt[wa3_o]. This is the same edge the register file writes, so a read in the following cycle sees the new value.
- Reservation and commit to the same register in one cycle: the counter is unchanged.
- rsv_ready_o = (cnt[rsv_addr_i] != max) || (we3_o && wa3_o == rsv_addr_i).
- Commit with cnt == 0: the counter stays 0 (no underflow) and err_o pulses in the following cycle.
- stall_o = (ra1_use_i && busy[ra1_i]) || (ra2_use_i && busy[ra2_i]). It is combinational from the counter state only, with no bypass from the in-flight write.

Decomposition:
- Package rf_wb_pkg holds:
  - ADDR_W/DATA_W/CNT_W defaults
  - typedef wb_req_t {valid, addr, data}
  - enum requester_e {REQ_ALU, REQ_MEM}
- Sub-module rr_arb2: 2-input round-robin arbiter holding the last-grant pointer (inputs req[1:0], advance; output one-hot gnt[1:0]).
- Scoreboard counters and write-port registers stay in the top module.

Test Plan:
- ALU only: reserve R3, then alu_valid_i with addr=3, data=0xA5, held for 1 cycle. Expect:
  - alu_ready_o=1 that cycle.
  - Next cycle we3_o=1, wa3_o=3, wd3_o=0xA5.
  - busy_o[3] 1 before the commit and 0 the cycle after.
- Contention: both valid for 4 consecutive cycles (ALU addr=1, MEM addr=2, all reserved). Expect grant order ALU, MEM, ALU, MEM, and wa3_o sequence 1, 2, 1, 2 one cycle later.
- Hazard: reserve R5, drive ra1_i=5 with ra1_use_i=1. Expect:
  - stall_o=1 until the cycle after we3_o=1 with wa3_o=5.
  - With ra1_use_i=0, stall_o=0.
- Saturation: 3 reservations to R7 with no commit. Expect:
  - rsv_ready_o=0 on a 4th attempt.
  - 4th attempt in the same cycle as a commit to R7: rsv_ready_o=1 and the counter stays 3.
- Unreserved write: MEM writes R9 with cnt=0. Expect the write to occur, err_o=1 for exactly one cycle, and busy_o[9]=0.
- Reset mid-operation: rst_i high in the cycle of an ALU transfer. Expect next cycle we3_o=0, busy_o=0, and ALU wins the next tie.
